// File: rtl/mac_accumulator_4b_pkg.sv
// mac_accumulator_4b_pkg: shared widths, FSM encoding and saturating add for the MAC stage
package mac_accumulator_4b_pkg;
  localparam int OP_WIDTH = 4;
  localparam int PROD_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  // Returns {overflow, value}; value clamps to max when the sum exceeds it.
  function automatic logic [32:0] sat_add(input logic [31:0] acc, input logic [PROD_WIDTH-1:0] prod,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, acc} + 33'(prod);
    return (sum > {1'b0, max}) ? {1'b1, max} : sum;
  endfunction
endpackage

// File: rtl/arr_multiplier_4b.sv
// arr_multiplier_4b: combinational 4x4 unsigned array multiplier; Prod is forced to zero while Reset is low
module arr_multiplier_4b
  import mac_accumulator_4b_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   A,
  input  logic [OP_WIDTH-1:0]   B,
  input  logic                  Reset,
  output logic [PROD_WIDTH-1:0] Prod
);
  logic [PROD_WIDTH-1:0] row [OP_WIDTH+1];
  assign row[0] = '0;
  for (genvar i = 0; i < OP_WIDTH; i++) begin : g_row
    assign row[i+1] = row[i] + (PROD_WIDTH'(A & {OP_WIDTH{B[i]}}) << i);
  end
  assign Prod = Reset ? row[OP_WIDTH] : '0;
endmodule

// File: rtl/mac_accumulator_4b.sv
// mac_accumulator_4b: two-stage pipelined multiply feeding a saturating dot-product accumulator
module mac_accumulator_4b
  import mac_accumulator_4b_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int LEN = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [OP_WIDTH-1:0]  InA,
  input  logic [OP_WIDTH-1:0]  InB,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [ACC_WIDTH-1:0] OutAcc,
  output logic                 Overflow
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  state_t state, next_state;
  logic [CW-1:0] accept_cnt, accum_cnt;
  logic [OP_WIDTH-1:0] op_a, op_b;
  logic [PROD_WIDTH-1:0] prod, prod_r;
  logic [ACC_WIDTH-1:0] acc;
  logic [32:0] sum;
  logic op_valid, prod_valid, ovf, accept, out_fire, last;
  assign accept = InValid & InReady;
  assign out_fire = OutValid & OutReady;
  assign last = prod_valid && (accum_cnt + CW'(1) == LEN_C);
  assign sum = sat_add(32'(acc), prod_r, 32'(ACC_MAX));
  arr_multiplier_4b u_mul (.A(op_a), .B(op_b), .Reset(1'b1), .Prod(prod));
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = Clear ? IDLE
      : (state == IDLE && accept) ? ACCUM
      : (state == ACCUM && last) ? DONE
      : (state == DONE && OutReady) ? IDLE
      : state;
  always_comb begin
    OutValid = state == DONE;
    InReady = state != DONE && accept_cnt < LEN_C;
    OutAcc = acc;
    Overflow = ovf;
  end
  // Bubbles flow through op_valid/prod_valid so only real products are counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_a <= '0;
      op_b <= '0;
      op_valid <= 1'b0;
      prod_r <= '0;
      prod_valid <= 1'b0;
      acc <= '0;
      ovf <= 1'b0;
      accept_cnt <= '0;
      accum_cnt <= '0;
    end else if (Clear || out_fire) begin
      op_valid <= 1'b0;
      prod_valid <= 1'b0;
      acc <= '0;
      ovf <= 1'b0;
      accept_cnt <= '0;
      accum_cnt <= '0;
    end else begin
      op_valid <= accept;
      if (accept) begin
        op_a <= InA;
        op_b <= InB;
        accept_cnt <= accept_cnt + CW'(1);
      end
      prod_valid <= op_valid;
      prod_r <= prod;
      if (prod_valid) begin
        acc <= ACC_WIDTH'(sum);
        ovf <= ovf | sum[32];
        accum_cnt <= accum_cnt + CW'(1);
      end
    end
  end
endmodule
